ddr_lane_judge: RTL

- Parametrised hit-judgement engine for the DDR game core. Sits between the arrow scroller, which pulses a per-lane arm when a note enters the hit window, and the score/HUD display.
- Per lane, a timing-window FSM grades each button press PERFECT/GOOD/MISS against the window centre.
- Aggregates score, current combo and max combo across all lanes each cycle.

---
 rtl/ddr_pkg.sv | 18 +
 rtl/ddr_lane_fsm.sv | 120 ++++++++++++
 rtl/ddr_lane_judge.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types for the DDR lane judge: grade encoding and lane FSM states.
package ddr_pkg;

  localparam int GRADE_W = 2;

  typedef enum logic [GRADE_W-1:0] {
    GR_NONE    = 2'd0,
    GR_PERFECT = 2'd1,
    GR_GOOD    = 2'd2,
    GR_MISS    = 2'd3
  } grade_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } lane_state_t;

endpackage

// File: rtl/ddr_lane_fsm.sv
// One lane's timing window: press edge detect, tick counter and PERFECT/GOOD/MISS grading.
// Macro DDR_STRAY_PENALTY_EN turns presses on an idle lane into MISS judgements.
//   state | meaning
//   IDLE  | no note in the window; presses are stray
//   OPEN  | note in window, r_cnt counts ticks 0..2*WIN_GOOD
module ddr_lane_fsm
  import ddr_pkg::*;
#(
  parameter int WIN_GOOD    = 4,
  parameter int WIN_PERFECT = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_tick,
  input  logic   i_arm,
  input  logic   i_btn,
  output logic   o_valid,
  output grade_t o_grade,
  output logic   o_open,
  output logic   o_ev_valid,
  output grade_t o_ev_grade
);

  localparam int CNT_W = $clog2(2*WIN_GOOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*WIN_GOOD);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(WIN_GOOD);
  localparam logic [CNT_W-1:0] DIST_PF  = CNT_W'(WIN_PERFECT);

  lane_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_btn_q;
  logic             r_valid;
  grade_t           r_grade;

  logic             w_press;
  logic             w_expire;
  logic [CNT_W-1:0] w_dist;
  logic             w_ev_valid;
  grade_t           w_ev_grade;

  assign w_press  = i_btn & ~r_btn_q;
  assign w_expire = i_tick && (r_cnt == CNT_LAST);
  assign w_dist   = (r_cnt >= CNT_MID) ? (r_cnt - CNT_MID) : (CNT_MID - r_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_btn_q <= 1'b0;
      r_valid <= 1'b0;
      r_grade <= GR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_btn_q <= i_btn;
      r_valid <= w_ev_valid;
      if (w_ev_valid) r_grade <= w_ev_grade;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_arm) begin
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = '0;
        end
      end
      ST_OPEN: begin
        // A new note always restarts the window, even when the old one is graded this cycle.
        if (i_arm) begin
          w_cnt_nxt = '0;
        end else if (w_press || w_expire) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_tick) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_ev_valid = 1'b0;
    w_ev_grade = GR_NONE;
    case (r_state)
      ST_IDLE: begin
`ifdef DDR_STRAY_PENALTY_EN
        if (w_press) begin
          w_ev_valid = 1'b1;
          w_ev_grade = GR_MISS;
        end
`endif
      end
      ST_OPEN: begin
        if (w_press) begin
          w_ev_valid = 1'b1;
          w_ev_grade = (w_dist <= DIST_PF) ? GR_PERFECT : GR_GOOD;
        end else if (i_arm || w_expire) begin
          w_ev_valid = 1'b1;
          w_ev_grade = GR_MISS;
        end
      end
      default: ;
    endcase
  end

  assign o_valid    = r_valid;
  assign o_grade    = r_grade;
  assign o_open     = (r_state == ST_OPEN);
  assign o_ev_valid = w_ev_valid;
  assign o_ev_grade = w_ev_grade;

endmodule

// File: rtl/ddr_lane_judge.sv
// DDR hit-judgement top: one ddr_lane_fsm per lane plus score/combo aggregation.
// Stray-press penalty is selected inside the lanes by DDR_STRAY_PENALTY_EN.
module ddr_lane_judge
  import ddr_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int WIN_GOOD    = 4,
  parameter int WIN_PERFECT = 1,
  parameter int PTS_PERFECT = 100,
  parameter int PTS_GOOD    = 50,
  parameter int SCORE_W     = 20,
  parameter int COMBO_W     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_LANES-1:0]         note_arm,
  input  logic [NUM_LANES-1:0]         btn,
  output logic [NUM_LANES-1:0]         judge_valid,
  output logic [GRADE_W*NUM_LANES-1:0] judge_grade,
  output logic [NUM_LANES-1:0]         lane_open,
  output logic [SCORE_W-1:0]           score,
  output logic [COMBO_W-1:0]           combo,
  output logic [COMBO_W-1:0]           max_combo
);

  localparam int PTS_W  = $clog2(NUM_LANES*PTS_PERFECT + 1);
  localparam int HIT_W  = $clog2(NUM_LANES + 1);
  localparam int SSUM_W = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;
  localparam int CSUM_W = ((COMBO_W > HIT_W) ? COMBO_W : HIT_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

  grade_t               w_grade    [NUM_LANES];
  grade_t               w_ev_grade [NUM_LANES];
  logic [NUM_LANES-1:0] w_ev_valid;

  logic [PTS_W-1:0]   w_pts;
  logic [HIT_W-1:0]   w_hits;
  logic               w_any_miss;
  logic [SSUM_W-1:0]  w_score_sum;
  logic [CSUM_W-1:0]  w_combo_sum;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [COMBO_W-1:0] w_combo_nxt;
  logic [COMBO_W-1:0] w_max_nxt;

  logic [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0] r_combo;
  logic [COMBO_W-1:0] r_max_combo;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    ddr_lane_fsm #(
      .WIN_GOOD    (WIN_GOOD),
      .WIN_PERFECT (WIN_PERFECT)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_tick     (tick),
      .i_arm      (note_arm[gi]),
      .i_btn      (btn[gi]),
      .o_valid    (judge_valid[gi]),
      .o_grade    (w_grade[gi]),
      .o_open     (lane_open[gi]),
      .o_ev_valid (w_ev_valid[gi]),
      .o_ev_grade (w_ev_grade[gi])
    );
    assign judge_grade[GRADE_W*gi +: GRADE_W] = w_grade[gi];
  end

  // Aggregate this cycle's (pre-register) lane events so totals land with the strobes.
  always_comb begin
    w_pts      = '0;
    w_hits     = '0;
    w_any_miss = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_ev_valid[i]) begin
        case (w_ev_grade[i])
          GR_PERFECT: begin
            w_pts  = w_pts + PTS_W'(PTS_PERFECT);
            w_hits = w_hits + HIT_W'(1);
          end
          GR_GOOD: begin
            w_pts  = w_pts + PTS_W'(PTS_GOOD);
            w_hits = w_hits + HIT_W'(1);
          end
          GR_MISS: w_any_miss = 1'b1;
          default: ;
        endcase
      end
    end

    w_score_sum = SSUM_W'(r_score) + SSUM_W'(w_pts);
    w_score_nxt = (w_score_sum > SSUM_W'(SCORE_MAX)) ? SCORE_MAX : w_score_sum[SCORE_W-1:0];

    w_combo_sum = CSUM_W'(r_combo) + CSUM_W'(w_hits);
    if (w_any_miss)
      w_combo_nxt = '0;
    else if (w_combo_sum > CSUM_W'(COMBO_MAX))
      w_combo_nxt = COMBO_MAX;
    else
      w_combo_nxt = w_combo_sum[COMBO_W-1:0];

    w_max_nxt = (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_score     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
    end else begin
      r_score     <= w_score_nxt;
      r_combo     <= w_combo_nxt;
      r_max_combo <= w_max_nxt;
    end
  end

  assign score     = r_score;
  assign combo     = r_combo;
  assign max_combo = r_max_combo;

endmodule
